// File: rtl/ebi_pkg.sv
// Shared EBI link definitions: beat widths, framing constants, opcodes and frame lengths.
// Imported by the link transceiver and by the on-chip transaction FSM.
package ebi_pkg;

  localparam int unsigned EBI_WIDTH        = 16;
  localparam int unsigned TX_PAYLOAD_BEATS = 35;
  localparam int unsigned RX_PAYLOAD_BEATS = 34;
  localparam int unsigned TX_DATA_W        = TX_PAYLOAD_BEATS * EBI_WIDTH;
  localparam int unsigned RX_DATA_W        = RX_PAYLOAD_BEATS * EBI_WIDTH;

  localparam logic [EBI_WIDTH-1:0] START = 16'hA55A;

  localparam logic [3:0] DR        = 4'd0;
  localparam logic [3:0] DW1       = 4'd1;
  localparam logic [3:0] DW2       = 4'd2;
  localparam logic [3:0] SNP_RESP1 = 4'd3;
  localparam logic [3:0] SNP_RESP2 = 4'd4;
  localparam logic [3:0] IDLE      = 4'd5;
  localparam logic [3:0] SNP_REQ   = 4'd6;
  localparam logic [3:0] RD_RESP   = 4'd7;
  localparam logic [3:0] ACK       = 4'd15;

  typedef enum logic [2:0] {
    StIdle,
    StTx,
    StTxTurn,
    StRxOp,
    StRxData
  } link_state_e;

  // Total beats in a frame (start + opcode + payload); 0 marks an illegal opcode.
  function automatic logic [5:0] beat_len(input logic [3:0] op);
    case (op)
      DR:        return 6'd6;
      DW1:       return 6'd37;
      DW2:       return 6'd5;
      SNP_RESP1: return 6'd34;
      SNP_RESP2: return 6'd2;
      SNP_REQ:   return 6'd5;
      RD_RESP:   return 6'd36;
      ACK:       return 6'd2;
      default:   return 6'd0;
    endcase
  endfunction

endpackage

// File: rtl/ebi_beat_len.sv
// Combinational opcode to frame-length lookup (0 = illegal opcode).
module ebi_beat_len
  import ebi_pkg::*;
(
  input  logic [3:0] opcode,
  output logic [5:0] len
);

  assign len = beat_len(opcode);

endmodule

// File: rtl/ebi_link_trx.sv
// EBI pin transceiver: serialises START/opcode/payload frames onto the 16-bit bus and
// captures incoming frames into a flat receive buffer. Receive wins over transmit in IDLE.
module ebi_link_trx
  import ebi_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 send_valid,
  output logic                 send_ready,
  input  logic [3:0]           send_opcode,
  input  logic [TX_DATA_W-1:0] send_data,
  output logic                 send_done,
  output logic                 rcv_start,
  output logic                 rcv_done,
  output logic [3:0]           rcv_opcode,
  output logic [RX_DATA_W-1:0] rcv_data,
  output logic                 rcv_err,
  input  logic [EBI_WIDTH-1:0] ebi_i,
  output logic [EBI_WIDTH-1:0] ebi_o,
  output logic [EBI_WIDTH-1:0] ebi_oen
);

  link_state_e          state_q, state_d;
  logic [5:0]           cnt_q, cnt_d;
  logic [3:0]           tx_op_q, tx_op_d;
  logic [TX_DATA_W-1:0] tx_data_q, tx_data_d;
  logic [5:0]           tx_len_q, tx_len_d;
  logic [5:0]           rx_len_q, rx_len_d;
  logic [EBI_WIDTH-1:0] ebi_o_q, ebi_o_d;
  logic [EBI_WIDTH-1:0] oen_q, oen_d;
  logic                 send_done_q, send_done_d;
  logic                 rcv_start_q, rcv_start_d;
  logic                 rcv_done_q, rcv_done_d;
  logic                 rcv_err_q, rcv_err_d;
  logic [3:0]           rcv_opcode_q, rcv_opcode_d;
  logic [RX_DATA_W-1:0] rcv_data_q, rcv_data_d;

  logic [5:0]           tx_len_new, rx_len_new;
  logic [5:0]           tx_nxt;
  logic [9:0]           tx_off, rx_off;
  logic [EBI_WIDTH-1:0] tx_word;

  ebi_beat_len u_tx_len (
    .opcode (send_opcode),
    .len    (tx_len_new)
  );

  ebi_beat_len u_rx_len (
    .opcode (ebi_i[3:0]),
    .len    (rx_len_new)
  );

  assign send_ready = (state_q == StIdle) && (ebi_i != START);

  // cnt_q is the beat currently on the bus; tx_word is the beat for the next cycle.
  always_comb begin
    tx_nxt  = cnt_q + 6'd1;
    tx_off  = (tx_nxt < 6'd2) ? 10'd0 : {tx_nxt - 6'd2, 4'b0000};
    tx_word = (tx_nxt == 6'd1) ? {12'b0, tx_op_q} : tx_data_q[tx_off +: EBI_WIDTH];
    rx_off  = {cnt_q, 4'b0000};
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tx_op_d      = tx_op_q;
    tx_data_d    = tx_data_q;
    tx_len_d     = tx_len_q;
    rx_len_d     = rx_len_q;
    ebi_o_d      = ebi_o_q;
    oen_d        = oen_q;
    send_done_d  = 1'b0;
    rcv_start_d  = 1'b0;
    rcv_done_d   = 1'b0;
    rcv_err_d    = 1'b0;
    rcv_opcode_d = rcv_opcode_q;
    rcv_data_d   = rcv_data_q;

    case (state_q)
      StIdle: begin
        if (ebi_i == START) begin
          state_d     = StRxOp;
          cnt_d       = 6'd0;
          rcv_start_d = 1'b1;
        end else if (send_valid && (tx_len_new != 6'd0)) begin
          // Illegal opcodes still complete the handshake but never reach the bus.
          state_d   = StTx;
          cnt_d     = 6'd0;
          tx_op_d   = send_opcode;
          tx_data_d = send_data;
          tx_len_d  = tx_len_new;
          ebi_o_d   = START;
          oen_d     = '0;
        end
      end
      StTx: begin
        if (cnt_q == tx_len_q - 6'd1) begin
          state_d = StTxTurn;
          ebi_o_d = '0;
          oen_d   = '1;
        end else begin
          cnt_d       = tx_nxt;
          ebi_o_d     = tx_word;
          send_done_d = (tx_nxt == tx_len_q - 6'd1);
        end
      end
      StTxTurn: state_d = StIdle;
      StRxOp: begin
        if (rx_len_new == 6'd0) begin
          rcv_err_d = 1'b1;
          state_d   = StIdle;
        end else if (rx_len_new == 6'd2) begin
          rcv_opcode_d = ebi_i[3:0];
          rcv_done_d   = 1'b1;
          state_d      = StIdle;
        end else begin
          rcv_opcode_d = ebi_i[3:0];
          rcv_data_d   = '0;
          rx_len_d     = rx_len_new;
          state_d      = StRxData;
        end
      end
      StRxData: begin
        // A START word here is ordinary payload.
        rcv_data_d[rx_off +: EBI_WIDTH] = ebi_i;
        if (cnt_q + 6'd3 == rx_len_q) begin
          rcv_done_d = 1'b1;
          state_d    = StIdle;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      tx_op_q      <= '0;
      tx_data_q    <= '0;
      tx_len_q     <= '0;
      rx_len_q     <= '0;
      ebi_o_q      <= '0;
      oen_q        <= '1;
      send_done_q  <= 1'b0;
      rcv_start_q  <= 1'b0;
      rcv_done_q   <= 1'b0;
      rcv_err_q    <= 1'b0;
      rcv_opcode_q <= '0;
      rcv_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tx_op_q      <= tx_op_d;
      tx_data_q    <= tx_data_d;
      tx_len_q     <= tx_len_d;
      rx_len_q     <= rx_len_d;
      ebi_o_q      <= ebi_o_d;
      oen_q        <= oen_d;
      send_done_q  <= send_done_d;
      rcv_start_q  <= rcv_start_d;
      rcv_done_q   <= rcv_done_d;
      rcv_err_q    <= rcv_err_d;
      rcv_opcode_q <= rcv_opcode_d;
      rcv_data_q   <= rcv_data_d;
    end
  end

  assign ebi_o      = ebi_o_q;
  assign ebi_oen    = oen_q;
  assign send_done  = send_done_q;
  assign rcv_start  = rcv_start_q;
  assign rcv_done   = rcv_done_q;
  assign rcv_err    = rcv_err_q;
  assign rcv_opcode = rcv_opcode_q;
  assign rcv_data   = rcv_data_q;

endmodule

// File: tb/tb_ebi_link_trx.sv
// Scoreboard bench for ebi_link_trx: stimulus tasks queue expected bus beats and receive
// events stamped with their cycle; a negedge monitor pops and compares as the DUT emits them.
module tb_ebi_link_trx;
  import ebi_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 send_valid = 1'b0;
  logic                 send_ready;
  logic [3:0]           send_opcode = '0;
  logic [TX_DATA_W-1:0] send_data = '0;
  logic                 send_done;
  logic                 rcv_start;
  logic                 rcv_done;
  logic [3:0]           rcv_opcode;
  logic [RX_DATA_W-1:0] rcv_data;
  logic                 rcv_err;
  logic [15:0]          ebi_i = '0;
  logic [15:0]          ebi_o;
  logic [15:0]          ebi_oen;

  ebi_link_trx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .send_valid  (send_valid),
    .send_ready  (send_ready),
    .send_opcode (send_opcode),
    .send_data   (send_data),
    .send_done   (send_done),
    .rcv_start   (rcv_start),
    .rcv_done    (rcv_done),
    .rcv_opcode  (rcv_opcode),
    .rcv_data    (rcv_data),
    .rcv_err     (rcv_err),
    .ebi_i       (ebi_i),
    .ebi_o       (ebi_o),
    .ebi_oen     (ebi_oen)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges so far; a value registered at edge e is seen with cyc == e.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {int cyc; logic [15:0] w; bit done;} tx_exp_t;
  typedef struct {int cyc; bit err; logic [3:0] op; logic [543:0] data;} rx_exp_t;

  tx_exp_t tx_q[$];
  rx_exp_t rx_q[$];
  int      start_q[$];
  tx_exp_t te;
  rx_exp_t re;
  int      se;

  logic [15:0]  bt [0:35];
  logic [543:0] hold_data;
  logic [3:0]   hold_op;

  task automatic chk(input string name, input logic [559:0] act, input logic [559:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [559:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h expected no event", name, act);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (ebi_oen == 16'h0000) begin
        if (tx_q.size() == 0) unexpected("tx_beat_unexpected", {cyc, ebi_o, send_done});
        else begin
          te = tx_q.pop_front();
          chk("tx_beat", {cyc, ebi_o, send_done}, {te.cyc, te.w, te.done});
        end
      end else begin
        if (ebi_oen !== 16'hFFFF) unexpected("oen_mixed", ebi_oen);
        if (send_done) unexpected("send_done_released", cyc);
      end
      if (rcv_start) begin
        if (start_q.size() == 0) unexpected("rcv_start_unexpected", cyc);
        else begin
          se = start_q.pop_front();
          chk("rcv_start_cycle", cyc, se);
        end
      end
      if (rcv_done || rcv_err) begin
        if (rx_q.size() == 0) unexpected("rx_event_unexpected", {cyc, rcv_err, rcv_done});
        else begin
          re = rx_q.pop_front();
          chk("rx_event", {cyc, rcv_err, rcv_done, rcv_opcode},
              {re.cyc, re.err, !re.err, re.op});
          chk("rx_data", rcv_data, re.data);
        end
      end
    end
  end

  // Drive bt[0..n-1] one beat per cycle; START is sampled at edge r.
  task automatic rx_frame(input int n, input bit err, input logic [3:0] op,
                          input logic [543:0] d, output int r);
    rx_exp_t e;
    @(posedge clk); #1;
    ebi_i = bt[0];
    r = cyc + 1;
    start_q.push_back(r);
    e.cyc  = err ? r + 1 : r + n - 1;
    e.err  = err;
    e.op   = op;
    e.data = d;
    rx_q.push_back(e);
    for (int k = 1; k < n; k++) begin
      @(posedge clk); #1;
      ebi_i = bt[k];
    end
    @(posedge clk); #1;
    ebi_i = 16'h0000;
  endtask

  // Request a send; t is the handshake edge. n = 0 means no beats are expected.
  task automatic send_req(input logic [3:0] op, input logic [559:0] d, input int n,
                          output int t);
    tx_exp_t e;
    int waited;
    @(posedge clk); #1;
    send_valid  = 1'b1;
    send_opcode = op;
    send_data   = d;
    waited = 0;
    t = -1;
    while (t < 0 && waited < 200) begin
      @(negedge clk);
      if (send_ready) t = cyc + 1;
      else waited++;
    end
    if (t < 0) unexpected("send_handshake_timeout", waited);
    else begin
      for (int k = 0; k < n; k++) begin
        e.cyc  = t + k;
        e.w    = (k == 0) ? START : (k == 1) ? {12'h000, op} : d[(k-2)*16 +: 16];
        e.done = (k == n - 1);
        tx_q.push_back(e);
      end
    end
    @(posedge clk); #1;
    send_valid = 1'b0;
  endtask

  task automatic tx_tail(input int t, input int n);
    int waited;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (cyc < t + n && waited < 200);
    chk("tx_release", {cyc, ebi_oen, ebi_o, send_ready}, {t + n, 16'hFFFF, 16'h0000, 1'b0});
    @(negedge clk);
    chk("send_ready_back", {cyc, send_ready}, {t + n + 1, 1'b1});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    int r;
    logic [559:0] d;
    logic [543:0] x;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state",
        {send_ready, ebi_oen, ebi_o, send_done, rcv_start, rcv_done, rcv_err, rcv_opcode},
        {1'b1, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0});
    chk("reset_rcv_data", rcv_data, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    hold_op   = 4'h0;
    hold_data = '0;

    // DW2 send: A55A 0002 1234 0000 0003
    d = '0;
    d[15:0]  = 16'h1234;
    d[31:16] = 16'h0000;
    d[47:32] = 16'h0003;
    send_req(4'd2, d, 5, t);
    tx_tail(t, 5);

    // ACK receive: opcode updates, data untouched
    bt[0] = START; bt[1] = 16'h000F;
    rx_frame(2, 1'b0, 4'hF, hold_data, r);
    hold_op = 4'hF;

    // RD_RESP receive: words 0..31, mesi 3, id 2
    bt[0] = START; bt[1] = 16'h0007;
    for (int j = 0; j < 32; j++) bt[j+2] = 16'(j);
    bt[34] = 16'h0003; bt[35] = 16'h0002;
    x = '0;
    for (int j = 0; j < 32; j++) x[j*16 +: 16] = 16'(j);
    x[527:512] = 16'h0003;
    x[543:528] = 16'h0002;
    rx_frame(36, 1'b0, 4'h7, x, r);
    hold_op = 4'h7;
    hold_data = x;

    // Illegal opcode 5: rcv_err only, held state unchanged
    bt[0] = START; bt[1] = 16'h0005;
    rx_frame(2, 1'b1, hold_op, hold_data, r);

    // DW2 receive with START inside the payload
    bt[0] = START; bt[1] = 16'h0002; bt[2] = 16'hBEEF; bt[3] = START; bt[4] = 16'h0042;
    x = '0;
    x[15:0]  = 16'hBEEF;
    x[31:16] = 16'hA55A;
    x[47:32] = 16'h0042;
    rx_frame(5, 1'b0, 4'h2, x, r);
    hold_op = 4'h2;
    hold_data = x;

    // Collision: SNP_REQ arrives as an ACK send is requested
    bt[0] = START; bt[1] = 16'h0006; bt[2] = 16'h0101; bt[3] = 16'h0202; bt[4] = 16'h0303;
    x = '0;
    x[15:0]  = 16'h0101;
    x[31:16] = 16'h0202;
    x[47:32] = 16'h0303;
    fork
      rx_frame(5, 1'b0, 4'h6, x, r);
      send_req(4'hF, '0, 2, t);
    join
    hold_op = 4'h6;
    hold_data = x;
    chk("collision_send_edge", t, r + 5);
    tx_tail(t, 2);

    // Illegal send opcode is swallowed
    send_req(4'd5, '1, 0, t);
    repeat (6) @(negedge clk);
    chk("illegal_send_idle", {ebi_oen, send_ready, send_done}, {16'hFFFF, 1'b1, 1'b0});

    // SNP_RESP2 send: minimum frame
    send_req(4'd4, '0, 2, t);
    tx_tail(t, 2);

    // DW1 send aborted by reset while beat 10 is on the bus
    d = '0;
    for (int j = 0; j < 35; j++) d[j*16 +: 16] = 16'hC000 + 16'(j);
    send_req(4'd1, d, 37, t);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_release", {ebi_oen, ebi_o, send_done}, {16'hFFFF, 16'h0000, 1'b0});
    chk("abort_pending_beats", tx_q.size(), 27);
    tx_q.delete();
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {send_ready, rcv_opcode}, {1'b1, 4'h0});
    chk("rcv_data_after_reset", rcv_data, '0);
    repeat (40) @(negedge clk);

    chk("queues_drained", {tx_q.size(), rx_q.size(), start_q.size()}, '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
